can_bit_stuff: RTL and testbench
================================

Name: can_bit_stuff

Overview:
- Bit-stream stuffing stage directly downstream of can_timing, operating on its sample_point / sampled_bit / tx_point strobes.
- RX path: removes stuff bits from the sampled stream, delivers destuffed bits to the frame decoder, and flags stuff errors.
- TX path: inserts a complementary stuff bit after STUFF_LEN equal bits, requests the next bit from the frame encoder, and drives the registered tx line value.

Parameters:
- STUFF_LEN, 5, number of consecutive equal bits that triggers a stuff bit (valid range 2..7).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_point_i  in  1  single-cycle strobe at the bit sample point.
- sampled_bit_i  in  1  bus value sampled at sample_point_i.
- tx_point_i  in  1  single-cycle strobe at the start of a bit time.
- stuff_en_i  in  1  high while the frame is inside the stuffed region (SOF through CRC sequence).
- clear_i  in  1  error or overload frame start; flushes all stuff state.
- tx_bit_i  in  1  next unstuffed bit from the frame encoder.
- rx_bit_o  out  1  destuffed received bit.
- rx_bit_valid_o  out  1  single-cycle strobe; rx_bit_o is valid.
- stuff_err_o  out  1  single-cycle stuff-error strobe.
- tx_bit_req_o  out  1  single-cycle strobe; tx_bit_i was consumed this cycle.
- tx_o  out  1  value driven on the CAN tx line (1 = recessive).

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is asynchronous, active-low.
  - Reset values: rx_bit_o=1, rx_bit_valid_o=0, stuff_err_o=0, tx_bit_req_o=0, tx_o=1.
  - Both counters reset to 0; both last-bit registers reset to 1.
- RX path, evaluated on each sample_point_i:
  - stuff_en_i=0: rx_bit_o<=sampled_bit_i, rx_bit_valid_o pulses next cycle, rx counter<=0.
  - stuff_en_i=1 and rx counter==STUFF_LEN, with sampled_bit_i != rx_last: bit is a stuff bit. No valid pulse; counter<=1; rx_last<=sampled_bit_i.
  - stuff_en_i=1 and rx counter==STUFF_LEN, with sampled_bit_i == rx_last: stuff_err_o pulses next cycle. No valid pulse; counter<=0.
  - stuff_en_i=1, otherwise: valid pulse. Counter<=counter+1 if the bit equals rx_last, else 1; rx_last<=sampled_bit_i.
  - Latency: rx_bit_valid_o and stuff_err_o are registered and rise exactly 1 clk after sample_point_i. They never assert in the same cycle.
- TX path, evaluated on each tx_point_i:
  - tx counter==STUFF_LEN with stuff_en_i=1: tx_o<=~tx_last, tx_last<=~tx_last, counter<=1. tx_bit_req_o stays 0 (encoder holds tx_bit_i).
  - Otherwise: tx_o<=tx_bit_i and tx_bit_req_o=1 combinationally in the tx_point_i cycle.
    - stuff_en_i=1: counter<=counter+1 if tx_bit_i==tx_last, else 1; tx_last<=tx_bit_i.
    - stuff_en_i=0: counter<=0, tx_last<=tx_bit_i.
- Stuff-region boundaries:
  - Counters accumulate only while stuff_en_i=1. The first stuffed-region bit (SOF) always loads counter=1.
  - A stuff bit pending after the final CRC bit is still emitted or checked if stuff_en_i is still high at that tx_point/sample_point.
  - The frame logic deasserts stuff_en_i only after that point.
- Precedence and concurrency:
  - clear_i has highest priority: counters<=0, lasts<=1, tx_o<=1, and no strobes in that cycle or the next.
  - sample_point_i and tx_point_i in the same cycle are processed independently; RX and TX state are fully separate.
- Counter width: ceil(log2(STUFF_LEN+1)) bits. The counter never exceeds STUFF_LEN; no wrap is possible.

Decomposition:
- can_defs.svh / package additions:
  - CAN_STUFF_LEN constant (5).
  - type_stuff_cnt_t typedef (3-bit).
  - type_stuff_rx_s struct {bit, valid, err} for the decoder interface.
- Sub-module can_stuff_counter, instantiated twice (rx, tx):
  - Inputs: strobe, bit, enable, clear.
  - Outputs: count, last, stuff_due (count==STUFF_LEN).

Test Plan:
1. stuff_en=1, RX sequence 0,0,0,0,0,1,0: 6 valid pulses (bits 0,0,0,0,0,0). The 1 is dropped, each valid pulse comes 1 clk after its sample_point, stuff_err_o stays 0.
2. stuff_en=1, RX sequence 1,1,1,1,1,1: 5 valid pulses, then stuff_err_o pulses once 1 clk after the 6th sample_point; counter reads 0.
3. TX tx_bit_i held 0 for 6 requests with stuff_en=1: tx_o = 0,0,0,0,0,1,0. tx_bit_req_o pulses at tx_points 1-5 and 7 only.
4. stuff_en=0, RX 7 consecutive 0s: 7 valid pulses, no stuff_err_o, counter stays 0.
5. clear_i asserted when rx counter==4 and tx counter==5: tx_o=1, counters 0. The next TX 0-bit is taken from tx_bit_i with tx_bit_req_o=1 (no stuff bit).
6. rst_n pulled low asynchronously mid-frame (between clk edges): all outputs reach reset values immediately. After release, pattern 1 reproduces correct results.

Source files
------------

// File: rtl/can_bit_stuff_pkg.sv
// Shared types and constants for the CAN bit-stuffing stage.
package can_bit_stuff_pkg;

  // Consecutive equal bits that force a complementary stuff bit.
  localparam int unsigned CAN_STUFF_LEN = 5;

  // Run-length counter type sized for the default stuff length.
  typedef logic [2:0] type_stuff_cnt_t;

  // Destuffed receive result handed to the frame decoder.
  typedef struct packed {
    logic rx_bit;
    logic valid;
    logic err;
  } type_stuff_rx_s;

  // Width of a run-length counter that must hold values 0..len.
  function automatic int unsigned stuff_cnt_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/can_bit_stuff_counter.sv
// Run-length tracker for one direction of the stuffing stage. Counts equal
// consecutive bits while enabled and flags when a stuff bit is due.
module can_bit_stuff_counter
  import can_bit_stuff_pkg::*;
#(
  parameter int unsigned StuffLen = CAN_STUFF_LEN,
  localparam int unsigned CntW = stuff_cnt_width(StuffLen)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            strobe_i,
  input  logic            bit_i,
  input  logic            enable_i,
  input  logic            clear_i,
  output logic [CntW-1:0] count_o,
  output logic            last_o,
  output logic            stuff_due_o
);

  logic [CntW-1:0] count_d, count_q;
  logic            last_d, last_q;

  assign stuff_due_o = (count_q == CntW'(StuffLen));
  assign count_o     = count_q;
  assign last_o      = last_q;

  // Next run length and last bit for each strobed bit.
  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    if (clear_i) begin
      count_d = '0;
      last_d  = 1'b1;
    end else if (strobe_i) begin
      if (!enable_i) begin
        count_d = '0;
        last_d  = bit_i;
      end else if (stuff_due_o) begin
        // A complementary bit here is the stuff bit; an equal bit is a violation.
        if (bit_i != last_q) begin
          count_d = CntW'(1);
          last_d  = bit_i;
        end else begin
          count_d = '0;
        end
      end else begin
        count_d = (bit_i == last_q) ? count_q + CntW'(1) : CntW'(1);
        last_d  = bit_i;
      end
    end
  end

  // Counter and last-bit state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      last_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/can_bit_stuff.sv
// CAN bit-stream stuffing stage: destuffs the sampled RX stream and inserts
// stuff bits into the TX stream, driven by the bit-timing strobes.
module can_bit_stuff
  import can_bit_stuff_pkg::*;
#(
  parameter int unsigned STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_point_i,
  input  logic sampled_bit_i,
  input  logic tx_point_i,
  input  logic stuff_en_i,
  input  logic clear_i,
  input  logic tx_bit_i,
  output logic rx_bit_o,
  output logic rx_bit_valid_o,
  output logic stuff_err_o,
  output logic tx_bit_req_o,
  output logic tx_o
);

  localparam int unsigned CntW = stuff_cnt_width(STUFF_LEN);

  logic            clear_q;
  logic            rx_strobe, tx_strobe;
  logic [CntW-1:0] rx_count, tx_count;
  logic            rx_last, tx_last;
  logic            rx_due, tx_due;
  logic            tx_stuff;
  logic            tx_bit_next;
  type_stuff_rx_s  rx_d, rx_q;
  logic            tx_d, tx_q;

  // Strobes are ignored in a clear cycle and the one after it.
  assign rx_strobe = sample_point_i & ~clear_i & ~clear_q;
  assign tx_strobe = tx_point_i & ~clear_i & ~clear_q;

  assign tx_stuff     = tx_due & stuff_en_i;
  assign tx_bit_next  = tx_stuff ? ~tx_last : tx_bit_i;
  assign tx_bit_req_o = tx_strobe & ~tx_stuff;

  can_bit_stuff_counter #(
    .StuffLen (STUFF_LEN)
  ) u_rx_cnt (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .strobe_i    (rx_strobe),
    .bit_i       (sampled_bit_i),
    .enable_i    (stuff_en_i),
    .clear_i     (clear_i),
    .count_o     (rx_count),
    .last_o      (rx_last),
    .stuff_due_o (rx_due)
  );

  // The TX counter sees the bit actually sent, so a stuff bit restarts the run.
  can_bit_stuff_counter #(
    .StuffLen (STUFF_LEN)
  ) u_tx_cnt (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .strobe_i    (tx_strobe),
    .bit_i       (tx_bit_next),
    .enable_i    (stuff_en_i),
    .clear_i     (clear_i),
    .count_o     (tx_count),
    .last_o      (tx_last),
    .stuff_due_o (tx_due)
  );

  // RX decode: deliver data bits, drop stuff bits, flag stuff violations.
  always_comb begin
    rx_d        = rx_q;
    rx_d.valid  = 1'b0;
    rx_d.err    = 1'b0;
    if (rx_strobe) begin
      if (!stuff_en_i || !rx_due) begin
        rx_d.rx_bit = sampled_bit_i;
        rx_d.valid  = 1'b1;
      end else if (sampled_bit_i == rx_last) begin
        rx_d.err = 1'b1;
      end
    end
  end

  // TX line value: recessive on clear, otherwise the data or stuff bit.
  always_comb begin
    tx_d = tx_q;
    if (clear_i) begin
      tx_d = 1'b1;
    end else if (tx_strobe) begin
      tx_d = tx_bit_next;
    end
  end

  // Output and clear-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q    <= '{rx_bit: 1'b1, valid: 1'b0, err: 1'b0};
      tx_q    <= 1'b1;
      clear_q <= 1'b0;
    end else begin
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      clear_q <= clear_i;
    end
  end

  assign rx_bit_o       = rx_q.rx_bit;
  assign rx_bit_valid_o = rx_q.valid & ~clear_i;
  assign stuff_err_o    = rx_q.err & ~clear_i;
  assign tx_o           = tx_q;

  // Run lengths are bounded by the stuff length.
  rx_cnt_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    rx_count <= CntW'(STUFF_LEN));
  tx_cnt_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    tx_count <= CntW'(STUFF_LEN));

endmodule

// File: tb/tb_can_bit_stuff.sv
// Directed bench for can_bit_stuff with hand-computed expected values.
module tb_can_bit_stuff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_point_i = 1'b0;
  logic sampled_bit_i = 1'b1;
  logic tx_point_i = 1'b0;
  logic stuff_en_i = 1'b1;
  logic clear_i = 1'b0;
  logic tx_bit_i = 1'b0;
  logic rx_bit_o, rx_bit_valid_o, stuff_err_o, tx_bit_req_o, tx_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  can_bit_stuff #(
    .STUFF_LEN (5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_point_i (sample_point_i),
    .sampled_bit_i  (sampled_bit_i),
    .tx_point_i     (tx_point_i),
    .stuff_en_i     (stuff_en_i),
    .clear_i        (clear_i),
    .tx_bit_i       (tx_bit_i),
    .rx_bit_o       (rx_bit_o),
    .rx_bit_valid_o (rx_bit_valid_o),
    .stuff_err_o    (stuff_err_o),
    .tx_bit_req_o   (tx_bit_req_o),
    .tx_o           (tx_o)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sample point; outputs checked one clock later.
  task automatic rx_step(input logic b, input logic ev, input logic eb, input logic ee,
                         input string tag);
    @(negedge clk);
    sample_point_i = 1'b1;
    sampled_bit_i  = b;
    @(negedge clk);
    sample_point_i = 1'b0;
    chk({tag, " valid"}, 8'(rx_bit_valid_o), 8'(ev));
    chk({tag, " err"}, 8'(stuff_err_o), 8'(ee));
    if (ev) chk({tag, " bit"}, 8'(rx_bit_o), 8'(eb));
  endtask

  // One tx point; request checked in the strobe cycle, line value after it.
  task automatic tx_step(input logic b, input logic ereq, input logic etx, input string tag);
    @(negedge clk);
    tx_point_i = 1'b1;
    tx_bit_i   = b;
    #1;
    chk({tag, " req"}, 8'(tx_bit_req_o), 8'(ereq));
    @(negedge clk);
    tx_point_i = 1'b0;
    chk({tag, " tx"}, 8'(tx_o), 8'(etx));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    @(negedge clk);
  endtask

  // 0,0,0,0,0 then stuff 1 (dropped) then 0.
  task automatic pattern1(input string tag);
    for (int i = 0; i < 5; i++) rx_step(1'b0, 1'b1, 1'b0, 1'b0, $sformatf("%s d%0d", tag, i));
    rx_step(1'b1, 1'b0, 1'b0, 1'b0, {tag, " stuff"});
    rx_step(1'b0, 1'b1, 1'b0, 1'b0, {tag, " d5"});
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst rx_bit", 8'(rx_bit_o), 8'd1);
    chk("rst valid", 8'(rx_bit_valid_o), 8'd0);
    chk("rst err", 8'(stuff_err_o), 8'd0);
    chk("rst req", 8'(tx_bit_req_o), 8'd0);
    chk("rst tx", 8'(tx_o), 8'd1);
    rst_n = 1'b1;

    // 1: destuffing
    stuff_en_i = 1'b1;
    pattern1("p1");

    // 2: six equal bits is a stuff error
    pulse_clear();
    for (int i = 0; i < 5; i++) rx_step(1'b1, 1'b1, 1'b1, 1'b0, $sformatf("p2 d%0d", i));
    rx_step(1'b1, 1'b0, 1'b0, 1'b1, "p2 err");
    chk("p2 rx count", 8'(dut.u_rx_cnt.count_o), 8'd0);
    @(negedge clk);
    chk("p2 err one-shot", 8'(stuff_err_o), 8'd0);

    // 3: TX stuffing with tx_bit_i held 0
    for (int i = 0; i < 5; i++) tx_step(1'b0, 1'b1, 1'b0, $sformatf("p3 t%0d", i));
    tx_step(1'b0, 1'b0, 1'b1, "p3 stuff");
    tx_step(1'b0, 1'b1, 1'b0, "p3 t5");

    // 4: no stuffing outside the stuffed region
    stuff_en_i = 1'b0;
    for (int i = 0; i < 7; i++) rx_step(1'b0, 1'b1, 1'b0, 1'b0, $sformatf("p4 d%0d", i));
    chk("p4 rx count", 8'(dut.u_rx_cnt.count_o), 8'd0);

    // 5: clear mid-run
    stuff_en_i = 1'b1;
    pulse_clear();
    for (int i = 0; i < 4; i++) rx_step(1'b0, 1'b1, 1'b0, 1'b0, $sformatf("p5 r%0d", i));
    for (int i = 0; i < 5; i++) tx_step(1'b0, 1'b1, 1'b0, $sformatf("p5 t%0d", i));
    chk("p5 rx count pre", 8'(dut.u_rx_cnt.count_o), 8'd4);
    chk("p5 tx count pre", 8'(dut.u_tx_cnt.count_o), 8'd5);
    @(negedge clk);
    clear_i        = 1'b1;
    sample_point_i = 1'b1;
    sampled_bit_i  = 1'b0;
    @(negedge clk);
    clear_i        = 1'b0;
    sample_point_i = 1'b0;
    chk("p5 tx after clear", 8'(tx_o), 8'd1);
    chk("p5 rx count", 8'(dut.u_rx_cnt.count_o), 8'd0);
    chk("p5 tx count", 8'(dut.u_tx_cnt.count_o), 8'd0);
    chk("p5 no valid", 8'(rx_bit_valid_o), 8'd0);
    @(negedge clk);
    chk("p5 no valid next", 8'(rx_bit_valid_o), 8'd0);
    tx_step(1'b0, 1'b1, 1'b0, "p5 post");
    chk("p5 tx count post", 8'(dut.u_tx_cnt.count_o), 8'd1);

    // 6: asynchronous reset mid-frame
    @(negedge clk);
    sample_point_i = 1'b1;
    sampled_bit_i  = 1'b0;
    tx_point_i     = 1'b1;
    tx_bit_i       = 1'b0;
    @(posedge clk);
    #2;
    sample_point_i = 1'b0;
    tx_point_i     = 1'b0;
    chk("p6 valid before rst", 8'(rx_bit_valid_o), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("p6 rx_bit", 8'(rx_bit_o), 8'd1);
    chk("p6 valid", 8'(rx_bit_valid_o), 8'd0);
    chk("p6 err", 8'(stuff_err_o), 8'd0);
    chk("p6 tx", 8'(tx_o), 8'd1);
    chk("p6 rx count", 8'(dut.u_rx_cnt.count_o), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pattern1("p6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
